multiplicador_booth_r4: RTL and testbench
=========================================

# multiplicador_booth_r4

Parametrised radix-4 Booth sequential multiplier: successor to the radix-2 `multiplicador`, retiring two multiplier bits per clock instead of one. Operand width is a parameter, latency is fixed per width, and a registered busy/done handshake allows back-to-back operations. It sits in the datapath as a multi-cycle arithmetic unit driven by a start pulse. Optional unsigned mode is selected per operation.

## Interface
- `NUM_BITS`, default 8: operand width N, N ≥ 2, odd or even.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `multiplicando` in N: operand M, captured on the accepted start edge.
- `multiplicador` in N: operand Q, captured on the accepted start edge.
- `sin_signo` in 1: present only with `MULT_UNSIGNED_EN`; 1 = treat operands as unsigned; captured with the operands.
- `resultado` out 2N: product, held stable until the next completion.
- `fin` out 1: one-cycle done pulse, coincident with `resultado` update.
- `ocupado` out 1: high from the accepted start edge until the completion edge.

## Operation
- Derived constants:
  - W = N+2 rounded up to even.
  - ITER = W/2 (N=3 → W=6, ITER=3; N=8 → W=10, ITER=5).
- Operand extension to W bits: sign extension in signed mode, zero extension in unsigned mode.
- Registers:
  - Accumulator A, W+2 bits, two's complement.
  - Multiplier shift register Q, W bits, plus guard bit q₋₁.
  - Extended multiplicand M, W bits.
  - Iteration counter, ⌈log2(ITER+1)⌉ bits.
- FSM:
  - IDLE, `start`=1 → CALC. Load A=0, Q=ext(multiplicador), q₋₁=0, M=ext(multiplicando), counter=ITER, `ocupado`←1.
  - CALC, each edge: recode {Q[1],Q[0],q₋₁}:
    - 000/111 → +0
    - 001/010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101/110 → −M
  - CALC, each edge: A ← A + partial product (W+2-bit arithmetic, M sign-extended), then arithmetic right shift of {A,Q,q₋₁} by 2. Decrement the counter.
  - CALC, last step (counter=1): `resultado` ← low 2N bits of the post-shift {A,Q}. `fin`←1, `ocupado`←0, state → IDLE.
  - Any state, next edge: `fin`←0 unless a new completion occurs.
- `start` while in CALC: ignored, no queuing.
- Overflow: none possible. The 2N-bit result is exact for all operand pairs, including −2^(N−1) × −2^(N−1) in signed mode and (2^N−1)² in unsigned mode.
- Inputs outside the start edge are don't-care; operand changes during CALC do not affect the result.

## Timing
- Reset values: `resultado`=0, `fin`=0, `ocupado`=0, state=IDLE, internal registers 0.
- Latency: start accepted at edge E0; `fin` and `resultado` are valid after edge E0+ITER (N=8: 5 edges).
- `fin` is high for exactly one cycle.
- Back-to-back: `start` high in the `fin` cycle is accepted at edge E0+ITER+1. Throughput is one product per ITER+1 cycles.
- `rst` during CALC: the operation is aborted, all outputs return to reset values, and no `fin` pulse is produced.
- `rst` and `start` on the same edge: reset wins, the request is dropped.

## Configuration
- `MULT_UNSIGNED_EN` defined: `sin_signo` port exists and selects zero or sign extension per operation.
- `MULT_UNSIGNED_EN` undefined: the port is absent, all operations are signed two's complement, and the extension logic reduces to sign extension.
- Latency is identical in both builds.

## Structure
- Package `mult_pkg` holds:
  - State enum (IDLE, CALC).
  - Functions computing W and ITER from N.
  - Recoder select encoding (ZERO, PM, P2M, NM, N2M).
- Sub-module `booth_r4_recoder`: combinational. Maps the 3-bit window to the select code, and select + M to the W+2-bit signed partial product.
- Top module holds the FSM, registers and counter.

## Test plan
- N=3 signed exhaustive sweep, all 64 pairs from −4..3 × −4..3 with back-to-back starts. Required: every `resultado` equals the 6-bit signed product (−4×−4 → 010000), `fin` arrives exactly 3 edges after each accepted start.
- N=8 signed corners:
  - −128×−128 → 16'h4000
  - 127×−128 → 16'hC080
  - 0×−1 → 0
  - Each completes in 5 cycles.
- `MULT_UNSIGNED_EN`, N=8, `sin_signo`=1:
  - 255×255 → 16'hFE01
  - 200×3 → 16'h0258
  - Same operands with `sin_signo`=0: 8'hFF×8'hFF → 16'h0001.
- Start while busy: N=8, 3×4 started, `start` pulsed again 2 cycles later with 5×5. Required: single `fin`, `resultado`=12, `ocupado` low only after completion.
- Reset mid-operation: N=8, 7×7 started, `rst` asserted after 2 steps. Required: outputs 0, no `fin`. A fresh 6×6 then completes → 36 in 5 cycles.
- Simultaneous `rst` and `start`: request dropped, `ocupado` stays 0, `fin` never asserts.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and size helpers for the radix-4 Booth multiplier.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package mult_pkg;

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    // Partial-product select produced by the Booth recoder.
    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } booth_sel_t;

    // Internal operand width: N+2 rounded up to even, so that every radix-4
    // step retires exactly two bits and the sign survives the extension.
    function automatic int calc_w(input int n);
        return ((n + 3) / 2) * 2;
    endfunction

    function automatic int calc_iter(input int n);
        return calc_w(n) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: 3-bit window {q1,q0,q-1} -> signed partial product.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_window (Booth window), i_m (W-bit extended multiplicand),
//        o_pp (W+2-bit two's complement partial product).
module booth_r4_recoder
    import mult_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [2:0]   i_window,
    input  logic [W-1:0] i_m,
    output logic [W+1:0] o_pp
);

    booth_sel_t   w_sel;
    logic [W+1:0] w_m1;
    logic [W+1:0] w_m2;

    // Sign-extend M and 2M into the accumulator width; -2M of the most
    // negative M still fits because of the two extra bits.
    assign w_m1 = {{2{i_m[W-1]}}, i_m};
    assign w_m2 = {i_m[W-1], i_m, 1'b0};

    always_comb begin
        w_sel = ZERO;
        case (i_window)
            3'b001, 3'b010: w_sel = PM;
            3'b011:         w_sel = P2M;
            3'b100:         w_sel = N2M;
            3'b101, 3'b110: w_sel = NM;
            default:        w_sel = ZERO;
        endcase
    end

    always_comb begin
        o_pp = '0;
        case (w_sel)
            PM:      o_pp = w_m1;
            P2M:     o_pp = w_m2;
            NM:      o_pp = -w_m1;
            N2M:     o_pp = -w_m2;
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/multiplicador_booth_r4.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per clock.
// Latency: ITER = (N+2 rounded up to even)/2 edges from accepted start to fin.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped.
// Ports: clk, rst (sync, active-high), start, multiplicando, multiplicador,
//        sin_signo (only with MULT_UNSIGNED_EN), resultado (2N), fin, ocupado.
// Build option: MULT_UNSIGNED_EN adds sin_signo for per-operation unsigned mode.
module multiplicador_booth_r4
    import mult_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_BITS-1:0]   multiplicando,
    input  logic [NUM_BITS-1:0]   multiplicador,
`ifdef MULT_UNSIGNED_EN
    input  logic                  sin_signo,
`endif
    output logic [2*NUM_BITS-1:0] resultado,
    output logic                  fin,
    output logic                  ocupado
);

    localparam int W     = calc_w(NUM_BITS);
    localparam int ITER  = calc_iter(NUM_BITS);
    localparam int CNT_W = $clog2(ITER + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [W+1:0]          r_a;
    logic [W-1:0]          r_q;
    logic                  r_q_m1;
    logic [W-1:0]          r_m;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*NUM_BITS-1:0] r_resultado;
    logic                  r_fin;
    logic                  r_ocupado;

    logic                  w_unsigned;
    logic [W-1:0]          w_ext_m;
    logic [W-1:0]          w_ext_q;
    logic [W+1:0]          w_pp;
    logic [W+1:0]          w_sum;
    logic [2*W+2:0]        w_shifted;
    logic                  w_last;

`ifdef MULT_UNSIGNED_EN
    assign w_unsigned = sin_signo;
`else
    assign w_unsigned = 1'b0;
`endif

    assign w_ext_m = {{(W-NUM_BITS){~w_unsigned & multiplicando[NUM_BITS-1]}}, multiplicando};
    assign w_ext_q = {{(W-NUM_BITS){~w_unsigned & multiplicador[NUM_BITS-1]}}, multiplicador};

    booth_r4_recoder #(
        .W (W)
    ) u_recoder (
        .i_window (r_q[1:0] == 2'b00 && !r_q_m1 ? 3'b000 : {r_q[1:0], r_q_m1}),
        .i_m      (r_m),
        .o_pp     (w_pp)
    );

    // One Booth step: add, then arithmetic shift of {A,Q,q-1} by two.
    assign w_sum     = r_a + w_pp;
    assign w_shifted = $signed({w_sum, r_q, r_q_m1}) >>> 2;
    assign w_last    = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_q         <= '0;
            r_q_m1      <= 1'b0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_resultado <= '0;
            r_fin       <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a       <= '0;
                        r_q       <= w_ext_q;
                        r_q_m1    <= 1'b0;
                        r_m       <= w_ext_m;
                        r_cnt     <= CNT_W'(ITER);
                        r_ocupado <= 1'b1;
                    end
                end
                CALC: begin
                    r_a    <= w_shifted[2*W+2:W+1];
                    r_q    <= w_shifted[W:1];
                    r_q_m1 <= w_shifted[0];
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        // The exact product fits in 2N bits, so the low
                        // bits of {A,Q} are the complete answer.
                        r_resultado <= w_shifted[2*NUM_BITS:1];
                        r_fin       <= 1'b1;
                        r_ocupado   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resultado = r_resultado;
    assign fin       = r_fin;
    assign ocupado   = r_ocupado;

endmodule

// File: tb/tb_multiplicador_booth_r4.sv
module tb_multiplicador_booth_r4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // N=8 instance
    logic        rst8, start8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        fin8, ocu8;
    // N=3 instance
    logic        rst3, start3;
    logic [2:0]  a3, b3;
    logic [5:0]  res3;
    logic        fin3, ocu3;
`ifdef MULT_UNSIGNED_EN
    logic        us8, us3;
`endif

    multiplicador_booth_r4 #(.NUM_BITS(8)) dut8 (
        .clk           (clk),
        .rst           (rst8),
        .start         (start8),
        .multiplicando (a8),
        .multiplicador (b8),
`ifdef MULT_UNSIGNED_EN
        .sin_signo     (us8),
`endif
        .resultado     (res8),
        .fin           (fin8),
        .ocupado       (ocu8)
    );

    multiplicador_booth_r4 #(.NUM_BITS(3)) dut3 (
        .clk           (clk),
        .rst           (rst3),
        .start         (start3),
        .multiplicando (a3),
        .multiplicador (b3),
`ifdef MULT_UNSIGNED_EN
        .sin_signo     (us3),
`endif
        .resultado     (res3),
        .fin           (fin3),
        .ocupado       (ocu3)
    );

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q3[$];
    exp_t e8, e3;

    // Reference: interpret raw n-bit operands, multiply as integers, keep 2n bits.
    function automatic logic [15:0] ref_prod(input int a_raw, input int b_raw,
                                             input int n, input bit us);
        longint va, vb, p, lim;
        va  = longint'(a_raw);
        vb  = longint'(b_raw);
        lim = longint'(1) << (n - 1);
        if (!us && va >= lim) va = va - (lim * 2);
        if (!us && vb >= lim) vb = vb - (lim * 2);
        p = va * vb;
        return 16'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Issued at a negedge; returns at the negedge of the fin cycle so the
    // next call lands back-to-back.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit us,
                       input bit push, input logic [15:0] expv);
        exp_t t;
        a8 = a; b8 = b; start8 = 1'b1;
`ifdef MULT_UNSIGNED_EN
        us8 = us;
`endif
        if (push) begin
            t.res = expv;
            t.cyc = cyc + 1 + 5;
            q8.push_back(t);
        end
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
`ifdef MULT_UNSIGNED_EN
        us8 = 1'($urandom);
`endif
        repeat (5) @(negedge clk);
    endtask

    task automatic go3(input logic [2:0] a, input logic [2:0] b);
        exp_t t;
        a3 = a; b3 = b; start3 = 1'b1;
`ifdef MULT_UNSIGNED_EN
        us3 = 1'b0;
`endif
        t.res = ref_prod(int'(a), int'(b), 3, 1'b0);
        t.cyc = cyc + 1 + 3;
        q3.push_back(t);
        @(negedge clk);
        start3 = 1'b0;
        a3 = 3'($urandom);
        b3 = 3'($urandom);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (fin8 === 1'b1) begin
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL n8_unexpected_fin actual=%0h required=no_fin", res8);
            end else begin
                e8 = q8.pop_front();
                if (res8 !== e8.res || cyc !== e8.cyc) begin
                    bad++;
                    $display("FAIL n8_result actual=%0h@%0d required=%0h@%0d",
                             res8, cyc, e8.res, e8.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (fin3 === 1'b1) begin
            total++;
            if (q3.size() == 0) begin
                bad++;
                $display("FAIL n3_unexpected_fin actual=%0h required=no_fin", res3);
            end else begin
                e3 = q3.pop_front();
                if (res3 !== e3.res[5:0] || cyc !== e3.cyc) begin
                    bad++;
                    $display("FAIL n3_result actual=%0h@%0d required=%0h@%0d",
                             res3, cyc, e3.res[5:0], e3.cyc);
                end
            end
        end
    end

    initial begin
        logic [7:0] ra, rb;
        bit         rus;
        rst8 = 1'b1; rst3 = 1'b1; start8 = 1'b0; start3 = 1'b0;
        a8 = '0; b8 = '0; a3 = '0; b3 = '0;
`ifdef MULT_UNSIGNED_EN
        us8 = 1'b0; us3 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_res8", res8, 0);
        chk("rst_fin8", fin8, 0);
        chk("rst_ocu8", ocu8, 0);
        chk("rst_res3", res3, 0);
        chk("rst_fin3", fin3, 0);
        chk("rst_ocu3", ocu3, 0);
        rst8 = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        // N=3 exhaustive, back-to-back
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                go3(3'(i), 3'(j));

        // N=8 signed corners
        go8(8'h80, 8'h80, 1'b0, 1'b1, 16'h4000);
        go8(8'h7F, 8'h80, 1'b0, 1'b1, 16'hC080);
        go8(8'h00, 8'hFF, 1'b0, 1'b1, 16'h0000);

`ifdef MULT_UNSIGNED_EN
        go8(8'hFF, 8'hFF, 1'b1, 1'b1, 16'hFE01);
        go8(8'd200, 8'd3, 1'b1, 1'b1, 16'h0258);
        go8(8'hFF, 8'hFF, 1'b0, 1'b1, 16'h0001);
`endif

        // Randomised operations with occasional idle gaps
        repeat (150) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rus = 1'b0;
`ifdef MULT_UNSIGNED_EN
            rus = 1'($urandom);
`endif
            go8(ra, rb, rus, 1'b1, ref_prod(int'(ra), int'(rb), 8, rus));
        end

        // Start while busy: second request must be ignored
        begin
            exp_t t;
            a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
`ifdef MULT_UNSIGNED_EN
            us8 = 1'b0;
`endif
            t.res = 16'd12;
            t.cyc = cyc + 1 + 5;
            q8.push_back(t);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("busy_ocupado_high", ocu8, 1);
            start8 = (k == 1);
            if (k == 1) begin
                a8 = 8'd5; b8 = 8'd5;
            end
        end
        @(negedge clk);
        chk("busy_ocupado_low", ocu8, 0);
        repeat (6) @(negedge clk);
        chk("busy_no_restart", ocu8, 0);

        // Reset mid-operation (7x7 never completes)
        a8 = 8'd7; b8 = 8'd7; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        chk("midrst_res", res8, 0);
        chk("midrst_fin", fin8, 0);
        chk("midrst_ocu", ocu8, 0);
        rst8 = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_res_hold", res8, 0);
        go8(8'd6, 8'd6, 1'b0, 1'b1, 16'd36);

        // Reset and start on the same edge: request dropped
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1; rst8 = 1'b1;
        @(negedge clk);
        chk("rststart_ocu", ocu8, 0);
        rst8 = 1'b0; start8 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("rststart_ocu_idle", ocu8, 0);
            chk("rststart_no_fin", fin8, 0);
        end

        repeat (10) @(negedge clk);
        chk("n8_pending", q8.size(), 0);
        chk("n3_pending", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
